// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, depths, framing byte counts and loader state encoding.
package imem_loader_pkg;
  localparam int DWIDTH = 32;
  localparam int MEMDEPTH = 1024;
  localparam int AWIDTH = $clog2(MEMDEPTH);
  localparam int WORD_BYTES = DWIDTH / 8;
  localparam int HDR_BYTES = 4;
  localparam int CSUM_BYTES = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: LSB-first 4-byte word assembly with a word-complete pulse on the last byte.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_take,
  input  logic [7:0]        i_byte,
  output logic [DWIDTH-1:0] o_word,
  output logic              o_done
);
  logic [1:0]        r_idx;
  logic [DWIDTH-9:0] r_shift;
  // The completed word is presented combinationally alongside its final byte.
  assign o_word = {i_byte, r_shift};
  assign o_done = i_take & (r_idx == 2'(WORD_BYTES - 1));
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_take) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[DWIDTH-9:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing the instruction memory and gating the core.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              wrEnable,
  output logic [DWIDTH-1:0] wrAddress,
  output logic [DWIDTH-1:0] wrData,
  output logic              coreHold,
  output logic              done,
  output logic              error
);
  state_t            r_state;
  logic              r_ready, r_wen, r_hold, r_done, r_err;
  logic [DWIDTH-1:0] r_waddr, r_wdata, r_csum;
  logic [AWIDTH:0]   r_count, r_widx;
  logic [DWIDTH-1:0] w_word;
  logic              w_wdone, w_take, w_idle, w_bad_len;
  logic [AWIDTH:0]   w_widx_nx;
  assign w_take    = byteValid & r_ready;
  assign w_idle    = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR);
  assign w_bad_len = (w_word == '0) | (w_word > DWIDTH'(MEMDEPTH));
  assign w_widx_nx = r_widx + (AWIDTH + 1)'(1);
  imem_byte_assembler u_asm (
    .clk    (clk),
    .reset  (reset),
    .i_clear(start & w_idle),
    .i_take (w_take),
    .i_byte (byteIn),
    .o_word (w_word),
    .o_done (w_wdone)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_wen   <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_csum  <= '0;
      r_count <= '0;
      r_widx  <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          r_state <= S_HDR;
          r_ready <= 1'b1;
          r_hold  <= 1'b1;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_csum  <= '0;
          r_widx  <= '0;
        end
        S_HDR: if (w_wdone) begin
          r_count <= w_word[AWIDTH:0];
          r_state <= w_bad_len ? S_ERR : S_DATA;
          r_ready <= ~w_bad_len;
          r_err   <= w_bad_len;
        end
        // The last payload write lands during CSUM, so it is never dropped.
        S_DATA: if (w_wdone) begin
          r_wen   <= 1'b1;
          r_wdata <= w_word;
          r_waddr <= DWIDTH'({r_widx[AWIDTH-1:0], 2'b00});
          r_csum  <= r_csum ^ w_word;
          r_widx  <= w_widx_nx;
          r_state <= (w_widx_nx == r_count) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (w_wdone) begin
          r_ready <= 1'b0;
          r_state <= (w_word == r_csum) ? S_DONE : S_ERR;
          r_done  <= (w_word == r_csum);
          r_err   <= (w_word != r_csum);
          r_hold  <= (w_word != r_csum);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign byteReady = r_ready;
  assign wrEnable  = r_wen;
  assign wrAddress = r_waddr;
  assign wrData    = r_wdata;
  assign coreHold  = r_hold;
  assign done      = r_done;
  assign error     = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench; a frame-level model predicts writes and final status.
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  logic        clk = 1'b0;
  logic        reset, start, byteValid;
  logic [7:0]  byteIn;
  logic        byteReady, wrEnable, coreHold, done, error;
  logic [31:0] wrAddress, wrData;
  int          total = 0;
  int          bad = 0;
  int          wen_cnt = 0;
  int          wen_mark;
  wr_t         sb[$];
  wr_t         exp_wr;
  bq_t         img;

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .byteIn   (byteIn),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .wrEnable (wrEnable),
    .wrAddress(wrAddress),
    .wrData   (wrData),
    .coreHold (coreHold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  initial forever begin
    @(negedge clk);
    if (wrEnable === 1'b1) begin
      wen_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", wrAddress, wrData);
      end else begin
        exp_wr = sb.pop_front();
        chk("wr_addr", wrAddress, exp_wr.a);
        chk("wr_data", wrData, exp_wr.d);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byteValid = 1'b0;
    repeat (gap) @(negedge clk);
    byteValid = 1'b1;
    byteIn = b;
    while (!byteReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready_low expected=ready_high");
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  function automatic bq_t build(input int cnt, input logic [31:0] flip);
    bq_t q;
    logic [31:0] x = 0;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) q.push_back(8'(cnt >> (8 * k)));
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      x ^= w;
      for (int k = 0; k < 4; k++) q.push_back(w[8*k+:8]);
    end
    x ^= flip;
    for (int k = 0; k < 4; k++) q.push_back(x[8*k+:8]);
    return q;
  endfunction

  // Model: decode the frame, predict each write and the final verdict, then stream it.
  task automatic run_image(input bq_t im, input int mode, input bit mid_start);
    logic [31:0] cnt, w, x, rx;
    bit ok, len_ok;
    int nsend, gap;
    cnt = {im[3], im[2], im[1], im[0]};
    len_ok = (cnt != 0) && (cnt <= 1024);
    x = 0;
    if (len_ok) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = {im[4*i+7], im[4*i+6], im[4*i+5], im[4*i+4]};
        sb.push_back('{32'(i * 4), w});
        x ^= w;
      end
      rx = {im[4*cnt+7], im[4*cnt+6], im[4*cnt+5], im[4*cnt+4]};
    end else rx = ~x;
    ok = len_ok && (rx == x);
    nsend = len_ok ? im.size() : 4;
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      gap = (mode == 0) ? 0 : (i % 2) + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      send(im[i], gap);
      if (mid_start && i == 5) pulse_start();
    end
    repeat (2) @(negedge clk);
    chk("done", 32'(done), 32'(ok));
    chk("error", 32'(error), 32'(!ok));
    chk("coreHold", 32'(coreHold), 32'(!ok));
    chk("ready_after", 32'(byteReady), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    byteValid = 1'b0;
    byteIn = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_coreHold", 32'(coreHold), 1);
    chk("rst_ready", 32'(byteReady), 0);
    chk("rst_wen", 32'(wrEnable), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_addr", wrAddress, 0);
    chk("rst_data", wrData, 0);
    byteValid = 1'b1;
    repeat (5) @(negedge clk);
    byteValid = 1'b0;
    chk("idle_ready", 32'(byteReady), 0);
    chk("idle_hold", 32'(coreHold), 1);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
            8'h93, 8'h00, 8'hE0, 8'h00, 8'h80, 8'h00, 8'hF0, 8'h00};
    run_image(img, 0, 1'b0);
    img[12] = 8'h81;
    run_image(img, 0, 1'b0);
    wen_mark = wen_cnt;
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_image(img, 0, 1'b0);
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_image(img, 0, 1'b0);
    chk("bad_hdr_no_writes", wen_cnt, wen_mark);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
            8'h93, 8'h00, 8'hE0, 8'h00, 8'h80, 8'h00, 8'hF0, 8'h00};
    run_image(img, 1, 1'b1);
    pulse_start();
    sb.push_back('{32'h0, 32'h00100013});
    for (int i = 0; i < 10; i++) send(img[i], 0);
    @(negedge clk);
    wen_mark = wen_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(byteReady), 0);
    chk("abort_wen", 32'(wrEnable), 0);
    chk("abort_hold", 32'(coreHold), 1);
    chk("abort_done", 32'(done), 0);
    repeat (4) @(negedge clk);
    chk("abort_no_writes", wen_cnt, wen_mark);
    chk("abort_sb", sb.size(), 0);
    run_image(img, 0, 1'b0);
    for (int t = 0; t < 6; t++)
      run_image(build($urandom_range(1, 8), ($urandom_range(0, 1) == 1) ? 32'(1 << $urandom_range(0, 31)) : 32'h0), t % 2, 1'b0);
    run_image(build(1024, 32'h0), 0, 1'b0);
    run_image(build(1, 32'h0), 1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
